fir_alu_sequencer: RTL

- Initiator-side driver for the processor's combinational ALU operand interface: operands A and B, the 4-bit ALU control and Result/Flags.
- Computes one FIR output per start request. It keeps a TAPS-deep sample delay line and issues MUL then ADD operations to the external ALU for each tap.
- It then issues a final SHIFT RIGHT for fixed-point scaling.
- It sits between the audio sample path and the shared ALU in the FIR datapath.

---
 rtl/fir_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_alu_sequencer.sv
// ---------------------------------------------------------------------------
// fir_alu_sequencer
//
// Sequences one FIR evaluation per start request over an external,
// combinational ALU. The block keeps a TAPS-deep sample delay line and, for
// every tap k, issues MUL (x[k] * coef[k]) followed by ADD (acc + prod). It
// then issues a SHIFT RIGHT by SHIFT for fixed-point scaling. The block does
// no arithmetic of its own apart from stepping the tap index.
//
// Optional build macro:
//   FIR_ROUND_EN - adds a ROUND state between the last ADD and SCALE. ROUND
//                  adds 1<<(SHIFT-1) to the accumulator, so SCALE rounds to
//                  nearest instead of truncating. It adds one cycle of latency.
//
// Ports:
//   clk, reset   - clock; synchronous active-high reset
//   start        - request one evaluation with sample_in (accepted in IDLE only)
//   sample_in    - new audio sample, captured when start is accepted
//   coef_addr    - coefficient ROM address (current tap index k)
//   coef_data    - coefficient, combinational read of coef_addr
//   alu_a/alu_b  - ALU operands (registered; alu_b passes coef_data in MUL)
//   alu_control  - ALU opcode: 0000 add, 0001 sub, 0010 mul, 0011 shift right
//   alu_result   - combinational ALU result
//   alu_flags    - ALU flags, bit 0 = signed overflow (V)
//   busy         - high in every state except IDLE
//   done         - one-cycle pulse when y_out is valid
//   y_out        - filtered output, held until the next done
//   ovf          - sticky add overflow for the current evaluation
//   dbg_state    - FSM state: 0 IDLE, 1 LOAD, 2 MUL, 3 ADD, 4 ROUND,
//                  5 SCALE, 6 DONE
//
// Handshake: start is a request sampled on the rising edge; it is accepted
// only while busy is low and is otherwise dropped (never queued). Each
// accepted start produces exactly one done pulse, with y_out and ovf valid
// from that cycle onward.
// ---------------------------------------------------------------------------
module fir_alu_sequencer #(
  parameter int WIDTH  = 32,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 15,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  sample_in,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [WIDTH-1:0]  coef_data,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [3:0]        alu_flags,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  y_out,
  output logic              ovf,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MUL   = 3'd2,
    S_ADD   = 3'd3,
    S_ROUND = 3'd4,
    S_SCALE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Opcode 0001 (sub) exists on the ALU but is never issued here.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_SRL = 4'b0011;

  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(TAPS - 1);
  localparam logic [WIDTH-1:0]  SHIFT_W = WIDTH'(SHIFT);
`ifdef FIR_ROUND_EN
  localparam logic [WIDTH-1:0]  ROUND_BIAS = WIDTH'(1) << (SHIFT - 1);
`endif

  // Architectural state
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  prod_q, prod_d;
  logic [WIDTH-1:0]  sample_q, sample_d;
  logic [WIDTH-1:0]  x_q [TAPS];
  logic [WIDTH-1:0]  x_d [TAPS];
  logic [WIDTH-1:0]  y_q, y_d;
  logic              ovf_q, ovf_d;

  // Registered ALU drive and status
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [3:0]        alu_ctl_q, alu_ctl_d;
  logic              done_q;
  logic              busy_q;

  // Only the overflow flag is consumed.
  logic              unused_flags;
  assign unused_flags = ^alu_flags[3:1];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      sample_q  <= '0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= OP_ADD;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      sample_q  <= sample_d;
      y_q       <= y_d;
      ovf_q     <= ovf_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_ctl_q <= alu_ctl_d;
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= x_d[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    sample_d = sample_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < TAPS; i++) begin
      x_d[i] = x_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sample_d = sample_in;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        x_d[0] = sample_q;
        for (int i = 1; i < TAPS; i++) begin
          x_d[i] = x_q[i-1];
        end
        acc_d   = '0;
        k_d     = '0;
        ovf_d   = 1'b0;
        state_d = S_MUL;
      end
      S_MUL: begin
        prod_d  = alu_result;
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d = alu_result;
        if (alu_flags[0]) begin
          ovf_d = 1'b1;
        end
        if (k_q == K_LAST) begin
`ifdef FIR_ROUND_EN
          state_d = S_ROUND;
`else
          state_d = S_SCALE;
`endif
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_MUL;
        end
      end
`ifdef FIR_ROUND_EN
      S_ROUND: begin
        acc_d   = alu_result;
        ovf_d   = ovf_q | alu_flags[0];
        state_d = S_SCALE;
      end
`endif
      S_SCALE: begin
        y_d     = alu_result;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // ALU drive for the state being entered. Computing it from the *next*
  // state and next register values lets the operands be registered while
  // still lining up with the state that uses them, so the ALU inputs only
  // move on clock edges.
  // -------------------------------------------------------------------------
  always_comb begin
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_ctl_d = OP_ADD;

    case (state_d)
      S_MUL: begin
        // alu_b is supplied from coef_data directly during MUL.
        alu_a_d   = x_d[k_d];
        alu_ctl_d = OP_MUL;
      end
      S_ADD: begin
        alu_a_d   = acc_d;
        alu_b_d   = prod_d;
        alu_ctl_d = OP_ADD;
      end
`ifdef FIR_ROUND_EN
      S_ROUND: begin
        alu_a_d   = acc_d;
        alu_b_d   = ROUND_BIAS;
        alu_ctl_d = OP_ADD;
      end
`endif
      S_SCALE: begin
        alu_a_d   = acc_d;
        alu_b_d   = SHIFT_W;
        alu_ctl_d = OP_SRL;
      end
      default: begin
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_ctl_d = OP_ADD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign coef_addr   = k_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = (state_q == S_MUL) ? coef_data : alu_b_q;
  assign alu_control = alu_ctl_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign y_out       = y_q;
  assign ovf         = ovf_q;
  assign dbg_state   = state_q;

endmodule
